// File: rtl/tva_pkg.sv
// Shared types and width helpers for the adaptive-precision A*V engine.
// Included by tva_prec_downcast and tva_av_precision_engine.
package tva_pkg;

    typedef enum logic [1:0] {
        PREC_LO   = 2'd0,
        PREC_MID  = 2'd1,
        PREC_FULL = 2'd2
    } prec_code_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_V,
        LOAD_A,
        PREC,
        MAC,
        OUT,
        DONE
    } av_state_t;

    function automatic int csum_w(input int dw, input int l);
        return dw + $clog2(l);
    endfunction

    function automatic int acc_w(input int dw, input int l);
        return 2 * dw + $clog2(l);
    endfunction

endpackage

// File: rtl/tva_prec_downcast.sv
// Per-lane V element masker: keeps LO_BITS, MID_BITS or all bits
// depending on the token's precision code.
module tva_prec_downcast
    import tva_pkg::*;
#(
    parameter int DW       = 16,
    parameter int LO_BITS  = 4,
    parameter int MID_BITS = 8
) (
    input  prec_code_t      code,
    input  logic [DW-1:0]   din,
    output logic [DW-1:0]   dout
);

    localparam logic [DW-1:0] LO_MASK  = DW'((64'd1 << LO_BITS) - 64'd1);
    localparam logic [DW-1:0] MID_MASK = DW'((64'd1 << MID_BITS) - 64'd1);

    always_comb begin
        dout = din;
        unique case (1'b1)
            (code == PREC_LO):  dout = din & LO_MASK;
            (code == PREC_MID): dout = din & MID_MASK;
            default:            dout = din;
        endcase
    end

endmodule

// File: rtl/tva_av_precision_engine.sv
// A*V stage with per-token adaptive V precision and streamed Z rows.
// Define TVA_AV_SATURATE_EN to saturate Z instead of wrapping.
module tva_av_precision_engine
    import tva_pkg::*;
#(
    parameter int DW       = 16,
    parameter int L        = 8,
    parameter int E        = 8,
    parameter int LO_BITS  = 4,
    parameter int MID_BITS = 8,
    parameter int TH_LO    = 100,
    parameter int TH_HI    = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              v_valid,
    output logic              v_ready,
    input  logic [DW*E-1:0]   v_data,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DW*L-1:0]   a_data,
    output logic              z_valid,
    input  logic              z_ready,
    output logic [DW*E-1:0]   z_data,
    output logic              z_last,
    output logic [2*L-1:0]    prec_codes
);

    localparam int CW  = $clog2(L);
    localparam int CSW = csum_w(DW, L);
    localparam int AW  = acc_w(DW, L);
    localparam int PW  = 2 * DW;
    localparam logic [CW-1:0]  LAST     = CW'(L - 1);
    localparam logic [CSW-1:0] TH_LO_C  = CSW'(TH_LO);
    localparam logic [CSW-1:0] TH_HI_C  = CSW'(TH_HI);

    av_state_t         state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     row;
    logic [DW*E-1:0]   v_buf  [L];
    logic [DW*L-1:0]   a_buf  [L];
    logic [CSW-1:0]    colsum [L];
    logic [AW-1:0]     acc     [E];
    logic [AW-1:0]     acc_nxt [E];
    logic [DW-1:0]     v_dc    [E];
    logic [DW-1:0]     a_el;
    logic [DW*E-1:0]   z_nxt;
    logic [2*L-1:0]    prec_q;
    prec_code_t        tok_code;
    prec_code_t        new_code;

    assign v_ready    = (state == LOAD_V);
    assign a_ready    = (state == LOAD_A);
    assign prec_codes = prec_q;
    assign tok_code   = prec_code_t'(prec_q[2*cnt +: 2]);
    assign a_el       = a_buf[row][cnt*DW +: DW];

    always_comb begin
        new_code = PREC_FULL;
        if (colsum[cnt] < TH_LO_C)
            new_code = PREC_LO;
        else if (colsum[cnt] < TH_HI_C)
            new_code = PREC_MID;
    end

    for (genvar e = 0; e < E; e++) begin : g_lane
        tva_prec_downcast #(
            .DW       (DW),
            .LO_BITS  (LO_BITS),
            .MID_BITS (MID_BITS)
        ) u_dc (
            .code (tok_code),
            .din  (v_buf[cnt][e*DW +: DW]),
            .dout (v_dc[e])
        );
    end

    always_comb begin
        z_nxt = '0;
        for (int e = 0; e < E; e++) begin
            acc_nxt[e] = acc[e] + AW'(PW'(a_el) * PW'(v_dc[e]));
`ifdef TVA_AV_SATURATE_EN
            z_nxt[e*DW +: DW] = (|acc_nxt[e][AW-1:DW]) ?
                                '1 : acc_nxt[e][DW-1:0];
`else
            z_nxt[e*DW +: DW] = acc_nxt[e][DW-1:0];
`endif
        end
    end

    // Buffers hold no reset: every job overwrites all L entries.
    always_ff @(posedge clk) begin
        if (v_ready && v_valid)
            v_buf[cnt] <= v_data;
        if (a_ready && a_valid)
            a_buf[cnt] <= a_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            row     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            z_valid <= 1'b0;
            z_last  <= 1'b0;
            z_data  <= '0;
            prec_q  <= '0;
            for (int l = 0; l < L; l++) colsum[l] <= '0;
            for (int e = 0; e < E; e++) acc[e] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD_V;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        prec_q <= '0;
                        for (int l = 0; l < L; l++) colsum[l] <= '0;
                    end
                end
                LOAD_V: begin
                    if (v_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= LOAD_A;
                        end
                    end
                end
                LOAD_A: begin
                    if (a_valid) begin
                        for (int l = 0; l < L; l++)
                            colsum[l] <= colsum[l] + CSW'(a_data[l*DW +: DW]);
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= PREC;
                        end
                    end
                end
                PREC: begin
                    prec_q[2*cnt +: 2] <= new_code;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        row   <= '0;
                        state <= MAC;
                        for (int e = 0; e < E; e++) acc[e] <= '0;
                    end
                end
                MAC: begin
                    for (int e = 0; e < E; e++) acc[e] <= acc_nxt[e];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        state   <= OUT;
                        z_valid <= 1'b1;
                        z_last  <= (row == LAST);
                        z_data  <= z_nxt;
                    end
                end
                OUT: begin
                    if (z_ready) begin
                        z_valid <= 1'b0;
                        z_last  <= 1'b0;
                        if (row == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            row   <= row + 1'b1;
                            state <= MAC;
                            for (int e = 0; e < E; e++) acc[e] <= '0;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
